id_ex_reg: RTL and testbench

//   ID/EX pipeline register of the 5-stage MIPS core. Captures decoded fields and control bits

---
 rtl/id_ex_reg_pkg.sv | 34 +++
 rtl/id_ex_reg_if.sv | 67 ++++++
 rtl/id_ex_reg_sat_counter.sv | 34 +++
 rtl/id_ex_reg.sv | 115 +++++++++++
 tb/tb_id_ex_reg.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_reg_pkg                                                |
// | Description : Shared constants for the ID/EX pipeline register: NOP and    |
// |               HALT opcodes, the ALU op class used for NOP, and the bit     |
// |               positions inside the 6-bit control bundle.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package id_ex_reg_pkg;

  localparam int NB_CTRL  = 6;
  localparam int NB_ALUOP = 2;
  localparam int NB_SHAMT = 5;

  // Opcode the ALU control decodes as "do nothing"
  localparam logic [5:0] NOP_OPCODE  = 6'b111000;
  // Opcode of the HALT instruction (marker is carried separately on i_halt)
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  // ALU op class presented with a NOP
  localparam logic [NB_ALUOP-1:0] ALUOP_ITYPE = 2'b11;

  // Control bundle layout: {regdst,alusrc,memread,memwrite,memtoreg,regwrite}
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;

  // Control image with every side effect disabled
  localparam logic [NB_CTRL-1:0] CTRL_NOP = 6'b000000;

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_reg_if                                                 |
// | Description : Bundle between decode stage, ID/EX register and execute      |
// |               stage. master = decode/debug side, slave = the register.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface id_ex_reg_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_OP   = 6,
  parameter int NB_BCNT = 16
) ();
  import id_ex_reg_pkg::*;

  // Step control
  logic                i_enable;
  logic                i_bubble;
  logic                i_flush;
  // Incoming decoded instruction
  logic [NB_DATA-1:0]  i_pc4;
  logic [NB_DATA-1:0]  i_rs_data;
  logic [NB_DATA-1:0]  i_rt_data;
  logic [NB_DATA-1:0]  i_imm;
  logic [NB_SHAMT-1:0] i_shamt;
  logic [NB_ADDR-1:0]  i_rs;
  logic [NB_ADDR-1:0]  i_rt;
  logic [NB_ADDR-1:0]  i_rd;
  logic [NB_OP-1:0]    i_opcode;
  logic [NB_OP-1:0]    i_funct;
  logic [NB_ALUOP-1:0] i_aluop;
  logic [NB_CTRL-1:0]  i_ctrl;
  logic                i_halt;
  // Registered instruction towards execute
  logic [NB_DATA-1:0]  o_pc4;
  logic [NB_DATA-1:0]  o_rs_data;
  logic [NB_DATA-1:0]  o_rt_data;
  logic [NB_DATA-1:0]  o_imm;
  logic [NB_SHAMT-1:0] o_shamt;
  logic [NB_ADDR-1:0]  o_rs;
  logic [NB_ADDR-1:0]  o_rt;
  logic [NB_ADDR-1:0]  o_rd;
  logic [NB_OP-1:0]    o_opcode;
  logic [NB_OP-1:0]    o_funct;
  logic [NB_ALUOP-1:0] o_aluop;
  logic [NB_CTRL-1:0]  o_ctrl;
  logic                o_halt;
  logic                o_valid;
  logic                o_halted;
  logic [NB_BCNT-1:0]  o_bubble_cnt;

  modport master (
    output i_enable, i_bubble, i_flush, i_pc4, i_rs_data, i_rt_data, i_imm, i_shamt,
           i_rs, i_rt, i_rd, i_opcode, i_funct, i_aluop, i_ctrl, i_halt,
    input  o_pc4, o_rs_data, o_rt_data, o_imm, o_shamt, o_rs, o_rt, o_rd, o_opcode,
           o_funct, o_aluop, o_ctrl, o_halt, o_valid, o_halted, o_bubble_cnt
  );

  modport slave (
    input  i_enable, i_bubble, i_flush, i_pc4, i_rs_data, i_rt_data, i_imm, i_shamt,
           i_rs, i_rt, i_rd, i_opcode, i_funct, i_aluop, i_ctrl, i_halt,
    output o_pc4, o_rs_data, o_rt_data, o_imm, o_shamt, o_rs, o_rt, o_rd, o_opcode,
           o_funct, o_aluop, o_ctrl, o_halt, o_valid, o_halted, o_bubble_cnt
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_reg_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_reg_sat_counter                                        |
// | Description : Up counter that increments when enabled and sticks at        |
// |               all-ones instead of wrapping.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_ex_reg_sat_counter #(
  parameter int NB = 16
) (
  input  wire logic          i_clock,
  input  wire logic          i_reset,
  input  wire logic          i_enable,
  output logic [NB-1:0]      o_count
);

  logic [NB-1:0] r_count;
  logic          w_at_max;

  assign w_at_max = &r_count;

  // Count enabled events, saturating at the maximum value
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_enable && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_reg                                                    |
// | Description : ID/EX pipeline register. Loads the decoded instruction when  |
// |               stepped, substitutes a NOP image on bubble/flush, latches a  |
// |               sticky halt flag and counts inserted bubbles.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_OP   = 6,
  parameter int NB_BCNT = 16
) (
  input  wire logic  i_clock,
  input  wire logic  i_reset,
  id_ex_reg_if.slave bus
);

  logic [NB_DATA-1:0]  r_pc4;
  logic [NB_DATA-1:0]  r_rs_data;
  logic [NB_DATA-1:0]  r_rt_data;
  logic [NB_DATA-1:0]  r_imm;
  logic [NB_SHAMT-1:0] r_shamt;
  logic [NB_ADDR-1:0]  r_rs;
  logic [NB_ADDR-1:0]  r_rt;
  logic [NB_ADDR-1:0]  r_rd;
  logic [NB_OP-1:0]    r_opcode;
  logic [NB_OP-1:0]    r_funct;
  logic [NB_ALUOP-1:0] r_aluop;
  logic [NB_CTRL-1:0]  r_ctrl;
  logic                r_halt;
  logic                r_valid;
  logic                r_halted;

  logic w_nop_load;
  logic w_normal_load;

  // Disabled steps freeze everything; bubble and flush collapse into one NOP load
  assign w_nop_load    = bus.i_enable &  (bus.i_bubble | bus.i_flush);
  assign w_normal_load = bus.i_enable & ~(bus.i_bubble | bus.i_flush);

  // Pipeline fields: reset and NOP load share the same side-effect-free image
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset || w_nop_load) begin
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_opcode  <= NOP_OPCODE;
      r_funct   <= '0;
      r_aluop   <= ALUOP_ITYPE;
      r_ctrl    <= CTRL_NOP;
      r_halt    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_normal_load) begin
      r_pc4     <= bus.i_pc4;
      r_rs_data <= bus.i_rs_data;
      r_rt_data <= bus.i_rt_data;
      r_imm     <= bus.i_imm;
      r_shamt   <= bus.i_shamt;
      r_rs      <= bus.i_rs;
      r_rt      <= bus.i_rt;
      r_rd      <= bus.i_rd;
      r_opcode  <= bus.i_opcode;
      r_funct   <= bus.i_funct;
      r_aluop   <= bus.i_aluop;
      r_ctrl    <= bus.i_ctrl;
      r_halt    <= bus.i_halt;
      r_valid   <= 1'b1;
    end
  end

  // Sticky halt: only a HALT that actually enters execute sets it
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_halted <= 1'b0;
    end else if (w_normal_load && bus.i_halt) begin
      r_halted <= 1'b1;
    end
  end

  id_ex_reg_sat_counter #(
    .NB (NB_BCNT)
  ) u_bubble_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (w_nop_load),
    .o_count  (bus.o_bubble_cnt)
  );

  assign bus.o_pc4     = r_pc4;
  assign bus.o_rs_data = r_rs_data;
  assign bus.o_rt_data = r_rt_data;
  assign bus.o_imm     = r_imm;
  assign bus.o_shamt   = r_shamt;
  assign bus.o_rs      = r_rs;
  assign bus.o_rt      = r_rt;
  assign bus.o_rd      = r_rd;
  assign bus.o_opcode  = r_opcode;
  assign bus.o_funct   = r_funct;
  assign bus.o_aluop   = r_aluop;
  assign bus.o_ctrl    = r_ctrl;
  assign bus.o_halt    = r_halt;
  assign bus.o_valid   = r_valid;
  assign bus.o_halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_id_ex_reg                                                 |
// | Description : Directed scoreboard bench for id_ex_reg. A second instance   |
// |               with a 4-bit bubble counter shares the stimulus so counter   |
// |               saturation is reachable in a few cycles.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_reg_if #(.NB_BCNT(16)) bus  ();
  id_ex_reg_if #(.NB_BCNT(4))  bus4 ();

  id_ex_reg #(.NB_BCNT(16)) dut  (.i_clock(clk), .i_reset(rst), .bus(bus.slave));
  id_ex_reg #(.NB_BCNT(4))  dut4 (.i_clock(clk), .i_reset(rst), .bus(bus4.slave));

  // Small instance mirrors the stimulus of the main one
  assign bus4.i_enable  = bus.i_enable;
  assign bus4.i_bubble  = bus.i_bubble;
  assign bus4.i_flush   = bus.i_flush;
  assign bus4.i_pc4     = bus.i_pc4;
  assign bus4.i_rs_data = bus.i_rs_data;
  assign bus4.i_rt_data = bus.i_rt_data;
  assign bus4.i_imm     = bus.i_imm;
  assign bus4.i_shamt   = bus.i_shamt;
  assign bus4.i_rs      = bus.i_rs;
  assign bus4.i_rt      = bus.i_rt;
  assign bus4.i_rd      = bus.i_rd;
  assign bus4.i_opcode  = bus.i_opcode;
  assign bus4.i_funct   = bus.i_funct;
  assign bus4.i_aluop   = bus.i_aluop;
  assign bus4.i_ctrl    = bus.i_ctrl;
  assign bus4.i_halt    = bus.i_halt;

  typedef struct {
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [5:0]  opcode, funct;
    logic [1:0]  aluop;
    logic [5:0]  ctrl;
    logic        halt;
  } in_t;

  typedef struct {
    in_t         f;
    logic        valid, halted;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic in_t nop_fields();
    in_t v;
    v.pc4 = '0; v.rs_data = '0; v.rt_data = '0; v.imm = '0;
    v.shamt = '0; v.rs = '0; v.rt = '0; v.rd = '0;
    v.opcode = 6'b111000; v.funct = '0; v.aluop = 2'b11; v.ctrl = '0; v.halt = 1'b0;
    return v;
  endfunction

  function automatic exp_t reset_image();
    exp_t e;
    e.f = nop_fields(); e.valid = 1'b0; e.halted = 1'b0; e.cnt = '0; e.cnt4 = '0;
    return e;
  endfunction

  function automatic in_t pat(input int k);
    in_t v;
    v.pc4     = 32'h0040_0000 + 32'(4 * k);
    v.rs_data = 32'hA5A5_0000 ^ 32'(k);
    v.rt_data = 32'h5A5A_FFFF - 32'(k);
    v.imm     = 32'hFFFF_8000 | 32'(k);
    v.shamt   = 5'(k + 3);
    v.rs      = 5'(k);
    v.rt      = 5'(k + 1);
    v.rd      = 5'(31 - k);
    v.opcode  = 6'(k + 8);
    v.funct   = 6'(k * 3);
    v.aluop   = 2'(k);
    v.ctrl    = 6'(k + 33);
    v.halt    = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the outputs are live after every clock edge and every reset assertion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc4",        bus.o_pc4,      e.f.pc4);
        chk("rs_data",    bus.o_rs_data,  e.f.rs_data);
        chk("rt_data",    bus.o_rt_data,  e.f.rt_data);
        chk("imm",        bus.o_imm,      e.f.imm);
        chk("shamt",      32'(bus.o_shamt),  32'(e.f.shamt));
        chk("rs",         32'(bus.o_rs),     32'(e.f.rs));
        chk("rt",         32'(bus.o_rt),     32'(e.f.rt));
        chk("rd",         32'(bus.o_rd),     32'(e.f.rd));
        chk("opcode",     32'(bus.o_opcode), 32'(e.f.opcode));
        chk("funct",      32'(bus.o_funct),  32'(e.f.funct));
        chk("aluop",      32'(bus.o_aluop),  32'(e.f.aluop));
        chk("ctrl",       32'(bus.o_ctrl),   32'(e.f.ctrl));
        chk("halt",       32'(bus.o_halt),   32'(e.f.halt));
        chk("valid",      32'(bus.o_valid),  32'(e.valid));
        chk("halted",     32'(bus.o_halted), 32'(e.halted));
        chk("bubble_cnt", 32'(bus.o_bubble_cnt),  32'(e.cnt));
        chk("bubble_cnt4", 32'(bus4.o_bubble_cnt), 32'(e.cnt4));
        chk("valid4",     32'(bus4.o_valid), 32'(e.valid));
      end
    end
  end

  task automatic apply(input logic en, input logic bub, input logic fl, input in_t v);
    bus.i_enable = en; bus.i_bubble = bub; bus.i_flush = fl;
    bus.i_pc4 = v.pc4; bus.i_rs_data = v.rs_data; bus.i_rt_data = v.rt_data;
    bus.i_imm = v.imm; bus.i_shamt = v.shamt; bus.i_rs = v.rs; bus.i_rt = v.rt;
    bus.i_rd = v.rd; bus.i_opcode = v.opcode; bus.i_funct = v.funct;
    bus.i_aluop = v.aluop; bus.i_ctrl = v.ctrl; bus.i_halt = v.halt;
  endtask

  // One clock step: drive inputs, predict the state after the next edge
  task automatic step(input logic en, input logic bub, input logic fl, input in_t v);
    @(negedge clk);
    apply(en, bub, fl, v);
    if (en) begin
      if (bub || fl) begin
        m.f = nop_fields();
        m.valid = 1'b0;
        if (m.cnt  != 16'hFFFF) m.cnt  = m.cnt + 16'd1;
        if (m.cnt4 != 4'hF)     m.cnt4 = m.cnt4 + 4'd1;
      end else begin
        m.f = v;
        m.valid = 1'b1;
        if (v.halt) m.halted = 1'b1;
      end
    end
    q.push_back(m);
  endtask

  // Asynchronous reset pulse between edges, followed by one held edge
  task automatic do_reset();
    @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, pat(7));
    m = reset_image();
    q.push_back(m);
    q.push_back(m);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    in_t v;
    apply(1'b0, 1'b0, 1'b0, pat(0));
    m = reset_image();
    do_reset();

    // Plain loads with distinct patterns
    step(1'b1, 1'b0, 1'b0, pat(3));
    step(1'b1, 1'b0, 1'b0, pat(4));
    // A bubble so the counter is nonzero before the mid-run reset
    step(1'b1, 1'b1, 1'b0, pat(5));
    step(1'b1, 1'b0, 1'b0, pat(6));
    // Reset with a loaded register
    do_reset();

    // Directed load with hand-chosen fields
    v = pat(1);
    v.rs_data = 32'h0000_00AA; v.aluop = 2'b10; v.funct = 6'b100001; v.ctrl = 6'b100001;
    step(1'b1, 1'b0, 1'b0, v);

    // Disabled: inputs toggle, bubble asserted, nothing may move
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'(i), pat(10 + i));

    // Bubble and flush together: one NOP, counter +1
    v = pat(20); v.ctrl = 6'b000101;
    step(1'b1, 1'b1, 1'b1, v);
    step(1'b1, 1'b0, 1'b0, pat(21));

    // Flushed HALT does not set halted; a real one does and it sticks
    v = pat(30); v.halt = 1'b1; v.opcode = HALT_OPCODE;
    step(1'b1, 1'b0, 1'b1, v);
    step(1'b1, 1'b1, 1'b0, v);
    step(1'b1, 1'b0, 1'b0, v);
    step(1'b1, 1'b1, 1'b0, pat(31));
    step(1'b1, 1'b0, 1'b1, pat(32));
    step(1'b1, 1'b0, 1'b0, pat(33));
    step(1'b0, 1'b0, 1'b0, pat(34));
    do_reset();

    // Long run of bubbles: the 4-bit counter saturates at F
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, pat(40 + i));
    step(1'b1, 1'b0, 1'b0, pat(2));
    step(1'b1, 1'b0, 1'b1, pat(9));

    // Drain: every prediction must have been consumed
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
